// File: rtl/key_draw_scheduler_if.sv
// Pixel-pipe bundle between the key draw scheduler and its environment:
// key-state input, sprite ROM port and vga_adapter write port.
interface key_draw_scheduler_if #(
    parameter int N_KEYS = 7
);
    logic [N_KEYS-1:0] key_states;
    logic              new_press;
    logic [2:0]        clr_on;
    logic [2:0]        clr_off;
    logic [12:0]       rom_addr;
    logic [7:0]        vga_x;
    logic [6:0]        vga_y;
    logic [2:0]        vga_color;
    logic              plot;
    logic              busy;

    modport master (
        output key_states, new_press, clr_on, clr_off,
        input  rom_addr, vga_x, vga_y, vga_color, plot, busy
    );

    modport slave (
        input  key_states, new_press, clr_on, clr_off,
        output rom_addr, vga_x, vga_y, vga_color, plot, busy
    );
endinterface

// File: rtl/key_draw_scheduler.sv
// Tracks key-state changes and redraws each changed key sprite, one at a time,
// by streaming its ROM pixels to a VGA adapter with round-robin key arbitration.
module key_draw_scheduler #(
    parameter int N_KEYS = 7,
    parameter int KEY_W  = 16,
    parameter int KEY_H  = 33,
    parameter int X_BASE = 120,
    parameter int X_STEP = 16,
    parameter int Y_BASE = 42
) (
    input  logic                 CLOCK_50,
    input  logic                 resetn,
    key_draw_scheduler_if.slave  bus
);
    localparam int IW = $clog2(N_KEYS);

    typedef enum logic [1:0] {IDLE, DRAW, FLUSH} state_t;

    state_t            r_state;
    logic [N_KEYS-1:0] r_pending;
    logic [N_KEYS-1:0] r_shadow;
    logic [IW-1:0]     r_rr;
    logic [IW-1:0]     r_sel;
    logic              r_kon;
    logic [4:0]        r_xc;
    logic [7:0]        r_yc;
    logic [7:0]        r_vga_x;
    logic [6:0]        r_vga_y;
    logic              r_plot;

    logic [IW-1:0]     w_gnt;
    logic              w_gnt_vld;
    logic              w_grant;
    logic [N_KEYS-1:0] w_pend_nxt;
    logic [7:0]        w_xpos;
    logic [6:0]        w_ypos;

    // Walk from the farthest candidate down so the first set key after rr wins.
    always_comb begin
        w_gnt     = '0;
        w_gnt_vld = 1'b0;
        for (int i = N_KEYS; i >= 1; i--) begin
            if (r_pending[(int'(r_rr) + i) % N_KEYS]) begin
                w_gnt     = IW'((int'(r_rr) + i) % N_KEYS);
                w_gnt_vld = 1'b1;
            end
        end
    end

    assign w_grant = (r_state == IDLE) && w_gnt_vld;

    // A change seen in the grant cycle re-arms the bit: the set is applied last.
    always_comb begin
        w_pend_nxt = r_pending;
        if (w_grant)
            w_pend_nxt[w_gnt] = 1'b0;
        if (bus.new_press)
            w_pend_nxt = w_pend_nxt | (bus.key_states ^ r_shadow);
    end

    assign w_xpos = 8'(X_BASE - X_STEP * int'(r_sel) + int'(r_xc));
    assign w_ypos = 7'(Y_BASE + int'(r_yc));

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_pending <= '1;
            r_shadow  <= '0;
            r_rr      <= IW'(N_KEYS - 1);
            r_sel     <= '0;
            r_kon     <= 1'b0;
            r_xc      <= '0;
            r_yc      <= '0;
            r_vga_x   <= '0;
            r_vga_y   <= '0;
            r_plot    <= 1'b0;
        end else begin
            r_pending <= w_pend_nxt;
            if (bus.new_press)
                r_shadow <= bus.key_states;
            r_plot <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt_vld) begin
                        r_sel   <= w_gnt;
                        r_kon   <= r_shadow[w_gnt];
                        r_rr    <= w_gnt;
                        r_xc    <= '0;
                        r_yc    <= '0;
                        r_state <= DRAW;
                    end
                end
                DRAW: begin
                    // Pixel coordinates trail the ROM address by the ROM's one-cycle latency.
                    r_vga_x <= w_xpos;
                    r_vga_y <= w_ypos;
                    r_plot  <= 1'b1;
                    if (r_xc == 5'(KEY_W - 1)) begin
                        r_xc <= '0;
                        if (r_yc == 8'(KEY_H - 1)) begin
                            r_yc    <= '0;
                            r_state <= FLUSH;
                        end else begin
                            r_yc <= r_yc + 8'd1;
                        end
                    end else begin
                        r_xc <= r_xc + 5'd1;
                    end
                end
                FLUSH:   r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.rom_addr  = (r_state == DRAW) ? {r_yc, r_xc} : 13'd0;
    assign bus.vga_x     = r_vga_x;
    assign bus.vga_y     = r_vga_y;
    assign bus.plot      = r_plot;
    assign bus.busy      = (r_state != IDLE);
    assign bus.vga_color = r_kon ? bus.clr_on : bus.clr_off;
endmodule

// File: tb/tb_key_draw_scheduler.sv
// Scoreboard bench: a transaction-level model queues every expected ROM address
// and pixel on each grant; a negedge monitor pops and compares DUT output.
module tb_key_draw_scheduler;
    localparam int DRAW_CYC = 16 * 33;

    logic clk;
    logic resetn;

    key_draw_scheduler_if #(.N_KEYS(7)) bus ();

    key_draw_scheduler dut (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] rom_on(input logic [12:0] a);
        return a[2:0] ^ a[7:5] ^ a[12:10];
    endfunction

    function automatic logic [2:0] rom_off(input logic [12:0] a);
        return ~rom_on(a);
    endfunction

    // Sprite ROM stand-in with one cycle of read latency.
    always @(posedge clk) begin
        bus.clr_on  <= rom_on(bus.rom_addr);
        bus.clr_off <= rom_off(bus.rom_addr);
    end

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    pix_t        pq[$];
    logic [12:0] aq[$];

    int n_vec = 0;
    int n_err = 0;
    int plots = 0;

    logic [6:0] m_pend   = 7'h7F;
    logic [6:0] m_shadow = 7'h00;
    int         m_rr     = 6;
    int         m_remain = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a draw occupies DRAW_CYC+1 cycles after its grant edge.
    initial begin
        int   sel;
        logic kon;
        logic found;
        pix_t p;
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                m_pend = 7'h7F; m_shadow = 7'h00; m_rr = 6; m_remain = 0;
                pq.delete(); aq.delete();
            end else begin
                if (m_remain > 0) begin
                    m_remain--;
                end else if (m_pend != 0) begin
                    found = 1'b0;
                    sel   = 0;
                    for (int i = 1; i <= 7; i++) begin
                        if (!found && m_pend[(m_rr + i) % 7]) begin
                            sel   = (m_rr + i) % 7;
                            found = 1'b1;
                        end
                    end
                    kon         = m_shadow[sel];
                    m_pend[sel] = 1'b0;
                    m_rr        = sel;
                    m_remain    = DRAW_CYC + 1;
                    for (int yc = 0; yc < 33; yc++) begin
                        for (int xc = 0; xc < 16; xc++) begin
                            aq.push_back({8'(yc), 5'(xc)});
                            p.x = 8'(120 - 16 * sel + xc);
                            p.y = 7'(42 + yc);
                            p.c = kon ? rom_on({8'(yc), 5'(xc)}) : rom_off({8'(yc), 5'(xc)});
                            pq.push_back(p);
                        end
                    end
                end
                if (bus.new_press) begin
                    m_pend   = m_pend | (bus.key_states ^ m_shadow);
                    m_shadow = bus.key_states;
                end
            end
        end
    end

    // Monitor
    initial begin
        int          run;
        pix_t        e;
        logic [12:0] a;
        run = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                check("rst_plot", bus.plot, 0);
                check("rst_busy", bus.busy, 0);
                check("rst_rom_addr", bus.rom_addr, 0);
                check("rst_vga_x", bus.vga_x, 0);
                check("rst_vga_y", bus.vga_y, 0);
                run = 0;
            end else begin
                check("busy", bus.busy, (m_remain > 0) ? 1 : 0);
                if (m_remain >= 2) begin
                    if (aq.size() == 0) check("addr_underflow", 1, aq.size());
                    else begin
                        a = aq.pop_front();
                        check("rom_addr", bus.rom_addr, a);
                    end
                end else begin
                    check("rom_addr_idle", bus.rom_addr, 0);
                end
                if (bus.plot) begin
                    plots++;
                    if (pq.size() == 0) check("pix_underflow", 1, pq.size());
                    else begin
                        e = pq.pop_front();
                        check("vga_x", bus.vga_x, e.x);
                        check("vga_y", bus.vga_y, e.y);
                        check("vga_color", bus.vga_color, e.c);
                    end
                end
                if (bus.busy) run++;
                else if (run != 0) begin
                    check("busy_len", run, DRAW_CYC + 1);
                    run = 0;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic press(input logic [6:0] ks);
        bus.key_states = ks;
        bus.new_press  = 1'b1;
        step();
        bus.new_press  = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while ((m_remain != 0 || m_pend != 0) && n < max) begin
            step();
            n++;
        end
        if (n >= max) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_idle: timed out after %0d cycles, required idle", n);
        end
    endtask

    task automatic wait_remain(input int r, input int max);
        int n;
        n = 0;
        while (m_remain != r && n < max) begin
            step();
            n++;
        end
        if (n >= max) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_remain: timed out after %0d cycles waiting for %0d", n, r);
        end
    endtask

    initial begin
        int p0;
        resetn         = 1'b1;
        bus.new_press  = 1'b0;
        bus.key_states = 7'h00;
        #1 resetn = 1'b0;
        repeat (3) step();
        resetn = 1'b1;

        // Full redraw after reset: keys 0..6 in order.
        p0 = plots;
        wait_idle(6000);
        check("reset_redraw_plots", plots - p0, 7 * DRAW_CYC);

        // Single key 2 pressed, drawn with the pressed sprite.
        p0 = plots;
        press(7'b0000100);
        wait_idle(1500);
        check("key2_plots", plots - p0, DRAW_CYC);

        // rr = 2: keys 6 then 0 (then 2, whose bit also toggles).
        p0 = plots;
        press(7'b1000001);
        wait_idle(3000);
        check("rr_plots", plots - p0, 3 * DRAW_CYC);

        // Key 3 toggled again during its own draw: redrawn afterwards.
        p0 = plots;
        press(7'b1001001);
        wait_remain(DRAW_CYC + 1, 20);
        repeat (100) step();
        press(7'b1000001);
        wait_idle(3000);
        check("redraw_plots", plots - p0, 2 * DRAW_CYC);

        // Reset at pixel 200 of a draw.
        press(7'b1000000);
        wait_remain(DRAW_CYC + 1 - 200, 800);
        @(posedge clk);
        #1;
        check("pre_rst_plot", bus.plot, 1);
        resetn = 1'b0;
        #1;
        check("async_rst_plot", bus.plot, 0);
        check("async_rst_busy", bus.busy, 0);
        repeat (3) step();
        resetn = 1'b1;
        p0 = plots;
        wait_idle(6000);
        check("rst_mid_redraw_plots", plots - p0, 7 * DRAW_CYC);

        // No change from shadow: no grant.
        press(7'b0000000);
        for (int i = 0; i < 5; i++) begin
            step();
            check("nochange_busy", bus.busy, 0);
        end

        // Random presses.
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 400)) step();
            press(7'($urandom));
        end
        wait_idle(8000);

        check("pix_queue_empty", pq.size(), 0);
        check("addr_queue_empty", aq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/key_draw_scheduler.md
KEY_DRAW_SCHEDULER -- requirements
Module: key_draw_scheduler

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  N_KEYS, 7, number of piano keys.
  KEY_W, 16, sprite width in pixels.
  KEY_H, 33, sprite height in pixels.
  X_BASE, 120, x origin of key 0.
  X_STEP, 16, x decrement per key index.
  Y_BASE, 42, y origin of all keys.
REQ-002 Ports, one per line (name, direction, width, meaning):
  CLOCK_50, in, 1, system clock, rising edge.
  resetn, in, 1, asynchronous active-low reset.
  key_states, in, 7, current pressed state per key (1 = pressed).
  new_press, in, 1, single-cycle strobe; key_states is valid in this cycle.
  clr_on, in, 3, pressed-sprite ROM data, valid one cycle after rom_addr.
  clr_off, in, 3, released-sprite ROM data, valid one cycle after rom_addr.
  rom_addr, out, 13, sprite ROM address {yc[7:0], xc[4:0]}.
  vga_x, out, 8, pixel x to vga_adapter.
  vga_y, out, 7, pixel y to vga_adapter.
  vga_color, out, 3, pixel colour to vga_adapter.
  plot, out, 1, pixel write enable to vga_adapter.
  busy, out, 1, high while a key is being drawn.
REQ-003 The block SHALL use one clock, CLOCK_50; resetn SHALL be asynchronous and active-low.

Function
REQ-004 The block SHALL hold a 7-bit shadow of key_states and a 7-bit pending mask, one bit per key.
REQ-005 On a new_press cycle: pending <= pending | (key_states ^ shadow); shadow <= key_states.
REQ-006 When a pending bit is set and cleared in the same cycle, the set SHALL win.
REQ-007 A new_press with no change from shadow SHALL leave pending unchanged.
REQ-008 The FSM SHALL have three states: IDLE, DRAW and FLUSH.
REQ-009 IDLE, pending != 0: grant one key by round-robin, searching upward from rr+1 with wrap modulo 7.
  - Latch sel = granted index and kon = shadow[sel].
  - Clear pending[sel] and set rr <= sel.
  - Set xc = 0 and yc = 0, then go to DRAW.
REQ-010 IDLE, pending == 0: remain in IDLE.
REQ-011 DRAW: each cycle rom_addr = {yc, xc} and xc increments.
  - When xc == KEY_W-1, xc wraps to 0 and yc increments.
  - When xc == KEY_W-1 and yc == KEY_H-1, go to FLUSH.
  - One key takes KEY_W*KEY_H = 528 DRAW cycles.
REQ-012 FLUSH SHALL last exactly one cycle, then go to IDLE. No back-to-back grant in the FLUSH cycle.
REQ-013 vga_x, vga_y and plot SHALL be registered one cycle after rom_addr, matching the 1-cycle ROM latency.
  - vga_x = X_BASE - X_STEP*sel + xc (8-bit).
  - vga_y = Y_BASE + yc (7-bit).
  - plot = 1 for each address issued in DRAW.
REQ-014 Exactly 528 plot pulses SHALL occur per granted key, the last one in the FLUSH cycle.
REQ-015 vga_color = kon ? clr_on : clr_off (combinational, aligned with plot).
REQ-016 kon and sel SHALL NOT change during DRAW/FLUSH, even if key_states changes.
REQ-017 A change of key sel during its own draw SHALL re-set pending[sel], so the key is redrawn after the current draw.
REQ-018 busy = (state != IDLE).
REQ-019 rom_addr SHALL be 0 in IDLE.

Reset
REQ-020 While resetn = 0, all of the following SHALL hold immediately, without waiting for a clock:
  - state = IDLE.
  - pending = 7'h7F, so all keys are drawn after reset.
  - shadow = 0.
  - rr = 6, so the first grant is key 0.
  - sel = 0, kon = 0, xc = 0, yc = 0.
  - rom_addr = 0, vga_x = 0, vga_y = 0, plot = 0, busy = 0.
REQ-021 Reset asserted mid-draw SHALL abort the draw with no further plot pulses; after release, full redraw per REQ-020.

Verification
REQ-022 The bench SHALL cover these directed scenarios (stimulus -> required response):
  - Reset release, no presses -> keys drawn in order 0..6, 528 plots each, 3696 total. Key 0 first pixel (120,42), last pixel (135,74), colour from clr_off. Key 6 x range 24..39.
  - Idle; new_press with key_states = 7'b0000100 -> only key 2 drawn, x 88..103, kon = 1, colour from clr_on; busy high 529 cycles.
  - Idle, rr = 2; new_press with 7'b1000001 -> key 6 drawn, then key 0.
  - new_press sets key 3 while key 3 is drawing -> that draw finishes with the old kon, then key 3 is redrawn with the new kon.
  - resetn pulsed low at pixel 200 of a draw -> plot = 0 in the same cycle; after release, the full 7-key redraw restarts at key 0.
  - new_press with key_states == shadow -> no grant; busy stays 0.
